// File: rtl/spgd_pkg.sv
// ---------------------------------------------------------------------------
// spgd_pkg
// Shared definitions for the SPGD update datapath:
//   - dac_sel_e : encoding of the sequencer's DAC_SEL field
//   - state_e   : iteration state of the update stage
//   - saturating helpers, evaluated in 64-bit signed arithmetic so that
//     intermediate sums of any of the datapath widths cannot overflow
// ---------------------------------------------------------------------------
package spgd_pkg;

  typedef enum logic [1:0] {
    SEL_OFF     = 2'b00,
    SEL_PLUS    = 2'b01,
    SEL_MINUS   = 2'b10,
    SEL_NOMINAL = 2'b11
  } dac_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC_A,
    ST_ACC_B,
    ST_CALC,
    ST_READY
  } state_e;

  localparam int LFSR_W = 16;

  // Clamp v into [lo, hi].
  function automatic longint sat_clamp(input longint v, input longint lo,
                                       input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Unsigned saturating add: result in [0, hi].
  function automatic longint sat_add_u(input longint a, input longint b,
                                       input longint hi);
    return sat_clamp(a + b, 64'sd0, hi);
  endfunction

  // Signed saturating add: result in [lo, hi].
  function automatic longint sat_add_s(input longint a, input longint b,
                                       input longint lo, input longint hi);
    return sat_clamp(a + b, lo, hi);
  endfunction

endpackage

// File: rtl/spgd_lfsr.sv
// ---------------------------------------------------------------------------
// spgd_lfsr
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying the perturbation sign
// vector. Bit i of the output selects the sign of channel i (0 = +1, 1 = -1).
// The register steps once per asserted i_adv.
//
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset, loads SEED
//   i_adv   advance enable (one step per cycle it is high)
//   o_sign  low N_OUT bits of the LFSR state
// ---------------------------------------------------------------------------
module spgd_lfsr
  import spgd_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                N_OUT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_adv,
  output logic [N_OUT-1:0] o_sign
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  // Right-shifting form: taps 16,14,13,11 map to state bits 0,2,3,5.
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_adv) begin
      r_lfsr <= {w_fb, r_lfsr[LFSR_W-1:1]};
    end
  end

  assign o_sign = r_lfsr[N_OUT-1:0];

endmodule

// File: rtl/spgd_update.sv
// ---------------------------------------------------------------------------
// spgd_update
// Datapath stage behind the SPGD sequencing FSM. Each iteration it drives the
// DAC with +/-DELTA perturbed control words, integrates the metric over phase
// A (J+) and phase B (J-), derives a clamped gradient step and, on the commit
// strobe, loads the updated control vector.
//
// Ports:
//   i_adc_clk      sole clock
//   i_rst          synchronous active-high reset
//   i_adc_data     unsigned metric sample, valid every cycle
//   i_fsm_dac_sel  00 off, 11 nominal, 01 +perturb, 10 -perturb
//   i_fsm_jp_wrt   end-of-phase-A strobe (latch J+)
//   i_fsm_jm_wrt   end-of-phase-B strobe (latch J-)
//   i_fsm_u_wrt    commit strobe for the new control vector
//   o_dac_out      per-channel DAC words, channel 0 in the LSBs
//   o_u_valid      one-cycle pulse the cycle after a commit
//   o_dj_out       signed J+ - J- of the last computed iteration
//   o_err          sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module spgd_update
  import spgd_pkg::*;
#(
  parameter int                N_CH       = 4,
  parameter int                DATA_W     = 14,
  parameter int                ACC_W      = 27,
  parameter int                U_W        = 14,
  parameter int                DELTA      = 64,
  parameter int                GAIN_SHIFT = 10,
  parameter int                STEP_MAX   = 256,
  parameter int                U_INIT     = 8192,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  i_adc_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_adc_data,
  input  logic [1:0]            i_fsm_dac_sel,
  input  logic                  i_fsm_jp_wrt,
  input  logic                  i_fsm_jm_wrt,
  input  logic                  i_fsm_u_wrt,
  output logic [N_CH*U_W-1:0]   o_dac_out,
  output logic                  o_u_valid,
  output logic signed [ACC_W:0] o_dj_out,
  output logic                  o_err
);

  localparam int     DJ_W    = ACC_W + 1;
  localparam longint U_MIN   = 64'sd0;
  localparam longint U_MAX   = (64'sd1 <<< U_W) - 64'sd1;
  localparam longint ACC_MAX = (64'sd1 <<< ACC_W) - 64'sd1;
  localparam longint DELTA_L = longint'(DELTA);
  localparam longint STEP_L  = longint'(STEP_MAX);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e                      r_state;
  logic [1:0]                  r_calc_cnt;
  logic [ACC_W-1:0]            r_acc;
  logic [ACC_W-1:0]            r_jp;
  logic [ACC_W-1:0]            r_jm;
  logic signed [DJ_W-1:0]      r_dj;
  logic signed [DJ_W-1:0]      r_step;
  logic [N_CH-1:0][U_W-1:0]    r_u;
  logic [N_CH-1:0][U_W-1:0]    r_u_next;
  logic [N_CH-1:0][U_W-1:0]    r_dac;
  logic                        r_u_valid;
  logic                        r_err;

  // -------------------------------------------------------------------------
  // Strobe qualification
  // -------------------------------------------------------------------------
  dac_sel_e         w_sel;
  logic             w_multi;
  logic             w_jp_ok;
  logic             w_jm_ok;
  logic             w_commit;
  logic             w_proto_err;
  logic [ACC_W-1:0] w_acc_sum;
  logic [N_CH-1:0]  w_sign;

  assign w_sel = dac_sel_e'(i_fsm_dac_sel);

  // Any two strobes together poison the whole cycle: none of them acts.
  assign w_multi = (i_fsm_jp_wrt & i_fsm_jm_wrt) |
                   (i_fsm_jp_wrt & i_fsm_u_wrt)  |
                   (i_fsm_jm_wrt & i_fsm_u_wrt);

  assign w_jp_ok  = i_fsm_jp_wrt & ~w_multi & (r_state == ST_ACC_A);
  assign w_jm_ok  = i_fsm_jm_wrt & ~w_multi & (r_state == ST_ACC_B);
  assign w_commit = i_fsm_u_wrt  & ~w_multi & (r_state == ST_READY);

  assign w_proto_err = w_multi |
                       (i_fsm_jp_wrt & (r_state != ST_ACC_A)) |
                       (i_fsm_jm_wrt & (r_state != ST_ACC_B)) |
                       (i_fsm_u_wrt  & (r_state != ST_READY));

  // Accumulator sum including the current sample, pinned at full scale.
  assign w_acc_sum = ACC_W'(sat_add_u(longint'(r_acc), longint'(i_adc_data),
                                      ACC_MAX));

  // -------------------------------------------------------------------------
  // Perturbation sign source
  // -------------------------------------------------------------------------
  spgd_lfsr #(
    .SEED  (LFSR_SEED),
    .N_OUT (N_CH)
  ) u_lfsr (
    .i_clk  (i_adc_clk),
    .i_rst  (i_rst),
    .i_adv  (w_commit),
    .o_sign (w_sign)
  );

  // -------------------------------------------------------------------------
  // Per-channel candidate words: +perturb, -perturb and gradient-stepped.
  // Sign bit 1 means s_i = -1.
  // -------------------------------------------------------------------------
  logic [N_CH-1:0][U_W-1:0] w_u_plus;
  logic [N_CH-1:0][U_W-1:0] w_u_minus;
  logic [N_CH-1:0][U_W-1:0] w_u_step;

  // NOTE: every element is written on every pass of this block, so no latch
  // can be inferred; new combinational outputs must keep that property.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_u_plus[i]  = U_W'(sat_add_s(longint'(r_u[i]),
                                    w_sign[i] ? -DELTA_L : DELTA_L,
                                    U_MIN, U_MAX));
      w_u_minus[i] = U_W'(sat_add_s(longint'(r_u[i]),
                                    w_sign[i] ? DELTA_L : -DELTA_L,
                                    U_MIN, U_MAX));
      w_u_step[i]  = U_W'(sat_add_s(longint'(r_u[i]),
                                    w_sign[i] ? -longint'(r_step)
                                              : longint'(r_step),
                                    U_MIN, U_MAX));
    end
  end

  // -------------------------------------------------------------------------
  // DAC output register: one cycle behind DAC_SEL. Because it reads r_u, a
  // word committed at an edge appears on the DAC from the following edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_adc_clk) begin
    if (i_rst) begin
      r_dac <= {N_CH{U_W'(U_INIT)}};
    end else begin
      case (w_sel)
        SEL_PLUS:  r_dac <= w_u_plus;
        SEL_MINUS: r_dac <= w_u_minus;
        default:   r_dac <= r_u;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Iteration control, accumulator, CALC pipeline and control vector.
  // -------------------------------------------------------------------------
  // NOTE: the control vector is a handful of flops, not a RAM, so it is
  // cleared by reset like every other register here.
  always_ff @(posedge i_adc_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_calc_cnt <= '0;
      r_acc      <= '0;
      r_jp       <= '0;
      r_jm       <= '0;
      r_dj       <= '0;
      r_step     <= '0;
      r_u        <= {N_CH{U_W'(U_INIT)}};
      r_u_next   <= {N_CH{U_W'(U_INIT)}};
      r_u_valid  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_u_valid <= w_commit;

      if (w_proto_err) begin
        r_err <= 1'b1;
      end

      // Commit is independent of the state transition below, so a commit in
      // READY may coincide with the start of the next phase A.
      if (w_commit) begin
        r_u <= r_u_next;
      end

      if (w_sel == SEL_OFF) begin
        // Abort: discard partial sums; u is retained.
        r_state    <= ST_IDLE;
        r_acc      <= '0;
        r_calc_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_READY: begin
            if (w_sel == SEL_PLUS) begin
              r_state <= ST_ACC_A;
              r_acc   <= ACC_W'(i_adc_data);
            end
          end

          ST_ACC_A: begin
            if (w_jp_ok) begin
              r_jp    <= w_acc_sum;
              r_acc   <= '0;
              r_state <= ST_ACC_B;
            end else begin
              r_acc <= w_acc_sum;
            end
          end

          ST_ACC_B: begin
            if (w_jm_ok) begin
              r_jm       <= w_acc_sum;
              r_acc      <= '0;
              r_calc_cnt <= '0;
              r_state    <= ST_CALC;
            end else begin
              r_acc <= w_acc_sum;
            end
          end

          ST_CALC: begin
            case (r_calc_cnt)
              2'd0: begin
                r_dj       <= $signed({1'b0, r_jp}) - $signed({1'b0, r_jm});
                r_calc_cnt <= 2'd1;
              end
              2'd1: begin
                // Arithmetic shift floors negative differences.
                r_step     <= DJ_W'(sat_clamp(longint'(r_dj >>> GAIN_SHIFT),
                                              -STEP_L, STEP_L));
                r_calc_cnt <= 2'd2;
              end
              default: begin
                r_u_next   <= w_u_step;
                r_calc_cnt <= '0;
                r_state    <= ST_READY;
              end
            endcase
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_dac_out = r_dac;
  assign o_u_valid = r_u_valid;
  assign o_dj_out  = r_dj;
  assign o_err     = r_err;

endmodule
